// File: rtl/tcb_pkg.sv
// Shared TCB library definitions.
//   tcb_arb_mode_t  : arbitration mode (round-robin / fixed priority)
//   tcb_arb_state_t : arbiter ownership state
package tcb_pkg;

  typedef enum logic {
    TCB_ARB_RR,
    TCB_ARB_FIXED
  } tcb_arb_mode_t;

  typedef enum logic [1:0] {
    FREE,
    HOLD,
    LOCK
  } tcb_arb_state_t;

endpackage : tcb_pkg

// File: rtl/tcb_lib_arbiter_pick.sv
// Combinational requester selector.
//   vld : request valid per requester
//   ptr : round-robin start index (ignored in fixed mode)
//   gnt : one-hot grant, all zero when nothing is valid
//   idx : granted index (0 when nothing is valid)
// Round-robin: first valid at or after ptr, searching upward with wrap.
// Fixed: highest valid index wins.
module tcb_lib_arbiter_pick
  import tcb_pkg::*;
#(
  parameter int unsigned   N    = 2,
  parameter tcb_arb_mode_t MODE = TCB_ARB_RR,
  parameter int unsigned   PW   = (N > 1) ? $clog2(N) : 1
)(
  input  logic [N-1:0]  vld,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int k;

  always_comb begin
    idx = '0;
    gnt = '0;
    k   = 0;
    if (MODE == TCB_ARB_RR) begin
      // Walk offsets from far to near so the nearest valid one wins.
      for (int off = int'(N) - 1; off >= 0; off--) begin
        k = int'(ptr) + off;
        if (k >= int'(N)) k = k - int'(N);
        if (vld[k]) idx = PW'(k);
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (vld[i]) idx = PW'(i);
      end
    end
    if (|vld) gnt[idx] = 1'b1;
  end

endmodule : tcb_lib_arbiter_pick

// File: rtl/tcb_lib_arbiter.sv
// TCB arbiter: shares one manager port among SPN requesters.
//   clk, rst           : clock, async active-high reset
//   sub_vld/lck/wen/adr/ben/wdt : per-requester request
//   sub_rdy            : per-requester ready
//   sub_rsp/rdt/err    : response strobe, broadcast read data, gated error
//   man_*              : muxed request to the manager, man_rdy/rdt/err back
// Grants are held across stalls (HOLD) and locked sequences (LOCK);
// responses return to the issuer DLY cycles after the transfer.
module tcb_lib_arbiter
  import tcb_pkg::*;
#(
  parameter  int unsigned SPN = 2,
  parameter  int unsigned ABW = 32,
  parameter  int unsigned DBW = 32,
  parameter  int unsigned SLW = 8,
  parameter  int unsigned DLY = 1,
  parameter  int unsigned RR  = 1,
  localparam int unsigned BEW = DBW / SLW,
  localparam int unsigned IW  = $clog2(SPN)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SPN-1:0]           sub_vld,
  input  logic [SPN-1:0]           sub_lck,
  input  logic [SPN-1:0]           sub_wen,
  input  logic [SPN-1:0][ABW-1:0]  sub_adr,
  input  logic [SPN-1:0][BEW-1:0]  sub_ben,
  input  logic [SPN-1:0][DBW-1:0]  sub_wdt,
  output logic [SPN-1:0]           sub_rdy,
  output logic [SPN-1:0]           sub_rsp,
  output logic [DBW-1:0]           sub_rdt,
  output logic [SPN-1:0]           sub_err,
  output logic                     man_vld,
  output logic                     man_lck,
  output logic                     man_wen,
  output logic [ABW-1:0]           man_adr,
  output logic [BEW-1:0]           man_ben,
  output logic [DBW-1:0]           man_wdt,
  input  logic                     man_rdy,
  input  logic [DBW-1:0]           man_rdt,
  input  logic                     man_err
);

  localparam tcb_arb_mode_t MODE = (RR != 0) ? TCB_ARB_RR : TCB_ARB_FIXED;

  tcb_arb_state_t state_q, state_d;
  logic [IW-1:0]  own_q, own_d, ptr_q, ptr_d;
  logic [IW-1:0]  own, pick_idx;
  logic [SPN-1:0] pick_gnt, own_oh;
  logic           trn;
  logic           rsp_vld;
  logic [IW-1:0]  rsp_idx;

  tcb_lib_arbiter_pick #(.N(SPN), .MODE(MODE), .PW(IW)) u_pick (
    .vld (sub_vld),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Only FREE re-arbitrates; otherwise the registered owner keeps the port.
  assign own    = (state_q == FREE) ? pick_idx : own_q;
  assign own_oh = (state_q == FREE) ? pick_gnt : (SPN'(1) << own_q);

  assign man_vld = (state_q == FREE) ? |sub_vld : sub_vld[own_q];
  assign man_lck = man_vld & sub_lck[own];
  assign man_wen = man_vld & sub_wen[own];
  assign man_adr = man_vld ? sub_adr[own] : '0;
  assign man_ben = man_vld ? sub_ben[own] : '0;
  assign man_wdt = man_vld ? sub_wdt[own] : '0;

  assign trn     = man_vld & man_rdy;
  assign sub_rdy = (man_vld & man_rdy) ? own_oh : '0;

  always_comb begin
    state_d = state_q;
    own_d   = own;
    ptr_d   = ptr_q;
    if (trn) ptr_d = (own == IW'(SPN - 1)) ? '0 : own + 1'b1;
    case (state_q)
      FREE: begin
        if (trn)          state_d = man_lck ? LOCK : FREE;
        else if (man_vld) state_d = HOLD;
      end
      HOLD, LOCK: begin
        if (trn) state_d = man_lck ? LOCK : FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
      own_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
    end
  end

  // Response routing: {valid, index} pushed every cycle, read at the tail.
  generate
    if (DLY == 0) begin : g_dly0
      assign rsp_vld = trn;
      assign rsp_idx = own;
    end else begin : g_pipe
      logic [DLY-1:0]         rsp_vld_q, rsp_vld_d;
      logic [DLY-1:0][IW-1:0] rsp_idx_q, rsp_idx_d;

      always_comb begin
        rsp_vld_d    = '0;
        rsp_idx_d    = '0;
        rsp_vld_d[0] = trn;
        rsp_idx_d[0] = own;
        for (int i = 1; i < int'(DLY); i++) begin
          rsp_vld_d[i] = rsp_vld_q[i-1];
          rsp_idx_d[i] = rsp_idx_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rsp_vld_q <= '0;
          rsp_idx_q <= '0;
        end else begin
          rsp_vld_q <= rsp_vld_d;
          rsp_idx_q <= rsp_idx_d;
        end
      end

      assign rsp_vld = rsp_vld_q[DLY-1];
      assign rsp_idx = rsp_idx_q[DLY-1];
    end
  endgenerate

  assign sub_rsp = rsp_vld ? (SPN'(1) << rsp_idx) : '0;
  assign sub_err = sub_rsp & {SPN{man_err}};
  assign sub_rdt = man_rdt;

endmodule : tcb_lib_arbiter

// File: tb/tb_tcb_lib_arbiter.sv
// Directed bench: three arbiter instances share one stimulus.
//   a: RR, DLY=1   b: fixed priority, DLY=1   c: RR, DLY=2
module tb_tcb_lib_arbiter;

  logic             clk, rst;
  logic [1:0]       sub_vld, sub_lck, sub_wen;
  logic [1:0][31:0] sub_adr, sub_wdt;
  logic [1:0][3:0]  sub_ben;
  logic             man_rdy, man_err;
  logic [31:0]      man_rdt;

  logic [1:0]  a_rdy, a_rsp, a_err, b_rdy, b_rsp, b_err, c_rdy, c_rsp, c_err;
  logic [31:0] a_rdt, b_rdt, c_rdt, a_adr, b_adr, c_adr, a_wdt, b_wdt, c_wdt;
  logic        a_vld, b_vld, c_vld, a_lck, b_lck, c_lck, a_wen, b_wen, c_wen;
  logic [3:0]  a_ben, b_ben, c_ben;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADR0 = 32'h8000_0010;
  localparam logic [31:0] ADR1 = 32'h9000_0020;

  tcb_lib_arbiter #(.SPN(2), .DLY(1), .RR(1)) u_a (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_lck(sub_lck), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdy(a_rdy),
    .sub_rsp(a_rsp), .sub_rdt(a_rdt), .sub_err(a_err), .man_vld(a_vld), .man_lck(a_lck),
    .man_wen(a_wen), .man_adr(a_adr), .man_ben(a_ben), .man_wdt(a_wdt),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err));

  tcb_lib_arbiter #(.SPN(2), .DLY(1), .RR(0)) u_b (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_lck(sub_lck), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdy(b_rdy),
    .sub_rsp(b_rsp), .sub_rdt(b_rdt), .sub_err(b_err), .man_vld(b_vld), .man_lck(b_lck),
    .man_wen(b_wen), .man_adr(b_adr), .man_ben(b_ben), .man_wdt(b_wdt),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err));

  tcb_lib_arbiter #(.SPN(2), .DLY(2), .RR(1)) u_c (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_lck(sub_lck), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdy(c_rdy),
    .sub_rsp(c_rsp), .sub_rdt(c_rdt), .sub_err(c_err), .man_vld(c_vld), .man_lck(c_lck),
    .man_wen(c_wen), .man_adr(c_adr), .man_ben(c_ben), .man_wdt(c_wdt),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, let combinational paths settle.
  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic r, input logic e);
    @(negedge clk);
    sub_vld = v; sub_lck = l; man_rdy = r; man_err = e;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sub_vld = '0; sub_lck = '0; sub_wen = 2'b10;
    sub_adr[0] = ADR0;          sub_adr[1] = ADR1;
    sub_wdt[0] = 32'h1111_1111; sub_wdt[1] = 32'h2222_2222;
    sub_ben[0] = 4'hF;          sub_ben[1] = 4'h3;
    man_rdy = 1'b0; man_err = 1'b0; man_rdt = 32'hDEAD_BEEF;

    // Reset state
    @(negedge clk); #1;
    chk("rst_man_vld", 32'(a_vld), 32'd0);
    chk("rst_sub_rdy", 32'(a_rdy), 32'd0);
    chk("rst_sub_rsp", 32'(a_rsp), 32'd0);
    chk("rst_sub_err", 32'(a_err), 32'd0);
    chk("rst_c_rsp",   32'(c_rsp), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Round-robin alternation, both valid, man_rdy=1
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 1'b1, 1'b0);
      chk("rr_rdy", 32'(a_rdy), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_adr", a_adr, (i % 2 == 0) ? ADR0 : ADR1);
      chk("rr_rsp", 32'(a_rsp), (i == 0) ? 32'd0 : ((i % 2 == 1) ? 32'd1 : 32'd2));
      chk("d2_rsp", 32'(c_rsp), (i < 2) ? 32'd0 : ((i % 2 == 0) ? 32'd1 : 32'd2));
      chk("fx_rdy", 32'(b_rdy), 32'd2);
      chk("fx_adr", b_adr, ADR1);
      if (i == 1) begin
        chk("rr_rdt", a_rdt, 32'hDEAD_BEEF);
        chk("rr_wen", 32'(a_wen), 32'd1);
        chk("rr_ben", 32'(a_ben), 32'h3);
        chk("rr_wdt", a_wdt, 32'h2222_2222);
      end
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    chk("idle_rsp",     32'(a_rsp), 32'd2);
    chk("idle_man_vld", 32'(a_vld), 32'd0);
    chk("idle_rdy",     32'(a_rdy), 32'd0);
    chk("idle_adr",     a_adr, 32'd0);
    chk("idle_d2_rsp",  32'(c_rsp), 32'd1);
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    chk("idle2_rsp",    32'(a_rsp), 32'd0);
    chk("idle2_d2_rsp", 32'(c_rsp), 32'd2);

    // Stall with sub0 granted; sub1 arrives during the stall
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    chk("st1_vld", 32'(a_vld), 32'd1);
    chk("st1_adr", a_adr, ADR0);
    chk("st1_rdy", 32'(a_rdy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 2'b00, 1'b0, 1'b0);
      chk("st_adr",    a_adr, ADR0);
      chk("st_fx_adr", b_adr, ADR0);
      chk("st_fx_rdy", 32'(b_rdy), 32'd0);
    end
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    chk("st_rel_rdy",    32'(a_rdy), 32'd1);
    chk("st_rel_fx_rdy", 32'(b_rdy), 32'd1);
    chk("st_rel_fx_adr", b_adr, ADR0);
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    chk("st_next_rdy",    32'(a_rdy), 32'd2);
    chk("st_next_rsp",    32'(a_rsp), 32'd1);
    chk("st_next_fx_rdy", 32'(b_rdy), 32'd2);
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    chk("st_tail_rsp", 32'(a_rsp), 32'd2);

    // Locked sequence from sub1 while sub0 waits
    drive(2'b10, 2'b10, 1'b1, 1'b0);
    chk("lk1_rdy", 32'(a_rdy), 32'd2);
    chk("lk1_lck", 32'(a_lck), 32'd1);
    drive(2'b11, 2'b10, 1'b1, 1'b0);
    chk("lk2_rdy", 32'(a_rdy), 32'd2);
    chk("lk2_lck", 32'(a_lck), 32'd1);
    chk("lk2_adr", a_adr, ADR1);
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    chk("lk3_rdy", 32'(a_rdy), 32'd2);
    chk("lk3_lck", 32'(a_lck), 32'd0);
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    chk("lk_after_rdy", 32'(a_rdy), 32'd1);
    chk("lk_after_rsp", 32'(a_rsp), 32'd2);
    chk("lk_after_err", 32'(a_err), 32'd0);

    // Error on sub0's response
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    chk("err_rsp", 32'(a_rsp), 32'd1);
    chk("err_err", 32'(a_err), 32'd1);
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    chk("err_gated", 32'(a_err), 32'd0);

    // Reset one cycle after a transfer in the DLY=2 instance
    drive(2'b01, 2'b00, 1'b1, 1'b0);
    chk("rs_trn_rdy", 32'(c_rdy), 32'd1);
    @(negedge clk);
    sub_vld = 2'b00; man_err = 1'b0; rst = 1'b1;
    #1;
    chk("rs_mid_rsp", 32'(c_rsp), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs_drop_rsp", 32'(c_rsp), 32'd0);
    chk("rs_man_vld",  32'(c_vld), 32'd0);
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    chk("rs_first_c", 32'(c_rdy), 32'd1);
    chk("rs_first_a", 32'(a_rdy), 32'd1);
    chk("rs_late_rsp", 32'(c_rsp), 32'd0);
    drive(2'b00, 2'b00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tcb_lib_arbiter
